lcd_bf_reader: RTL and testbench
================================

# lcd_bf_reader

LCD read-cycle controller for the HD44780-style character display. It is the read-side counterpart to the LCD write path. It executes bus read cycles (RW=1) to fetch either the status byte (busy flag + address counter, RS=0) or a data byte (RS=1), with E-pulse timing generated from cycle counts. It can poll the busy flag until it clears, so the write sequencer can wait on BF instead of fixed delays. At top level it sits beside the LCD writer; `bus_own` steers the shared LCD pins to this block.

## Interface
- `T_AS_CYC`, 2: RS/RW setup cycles before E rises (min 1)
- `T_EH_CYC`, 25: E high width in cycles; 500 ns at 50 MHz (min 1)
- `T_EL_CYC`, 25: E low/hold cycles after E falls (min 1)
- `MAX_POLLS`, 255: maximum status reads per polled request (min 1)
- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `req` in 1: start a read; accepted only when `ready`=1
- `rs_sel` in 1: 0 = status read, 1 = data read; sampled with `req`
- `poll` in 1: with `rs_sel`=0, repeat status reads until BF=0; ignored when `rs_sel`=1
- `ready` out 1: idle, can accept `req`
- `done` out 1: one-cycle pulse; result outputs are valid
- `rdata` out 8: last byte read
- `busy_flag` out 1: `rdata[7]` of the last status read
- `addr_cnt` out 7: `rdata[6:0]` of the last status read
- `timeout` out 1: poll gave up after `MAX_POLLS`; valid with `done`
- `lcd_rs` out 1: LCD register select
- `lcd_rw` out 1: LCD read/write; 1 during a transaction
- `lcd_e` out 1: LCD enable strobe
- `lcd_db_in` in 8: LCD data bus input (tri-state handled at top level)
- `bus_own` out 1: high while this block drives `lcd_rs`/`lcd_rw`/`lcd_e`

## Operation
- States and transitions:
  - IDLE: `ready`=1. On `req`, capture `rs_sel`/`poll`, clear `timeout` and the poll count, go to SETUP.
  - SETUP: lasts `T_AS_CYC` cycles. `bus_own`=1, `lcd_rw`=1, `lcd_rs`=captured `rs_sel`, `lcd_e`=0.
  - E_HIGH: lasts `T_EH_CYC` cycles with `lcd_e`=1. `lcd_db_in` is registered on the clock edge that ends E_HIGH.
  - E_LOW: lasts `T_EL_CYC` cycles with `lcd_e`=0, RS/RW held.
  - DONE: one cycle. `done`=1, `bus_own`=0, `lcd_rw`=0. Then IDLE.
- Exit from E_LOW:
  - Not polled: go to DONE.
  - Polled, BF=1, poll count < `MAX_POLLS`: go to SETUP for another read. The count increments per E pulse.
  - Polled, BF=0: go to DONE.
  - Polled, BF=1, count == `MAX_POLLS`: go to DONE with `timeout`=1.
- `busy_flag`/`addr_cnt` update only on status reads. `rdata` updates on every read. All result outputs hold until overwritten.
- `req` while `ready`=0 is ignored; it is not queued.
- Reset values: `ready`=1, all other outputs 0, state IDLE.
- Reset mid-transaction: `lcd_e`, `bus_own` and `lcd_rw` drop immediately (async). No `done` is issued.

## Timing
- `req` is accepted at edge 0. SETUP occupies the following `T_AS_CYC` cycles, then E_HIGH, then E_LOW.
- `done` is high in cycle `T_AS_CYC+T_EH_CYC+T_EL_CYC+1` after acceptance.
- `ready` returns to 1 in the cycle after `done`. A new `req` can be accepted that cycle, so back-to-back reads have no gap beyond DONE.
- Each poll iteration adds `T_AS_CYC+T_EH_CYC+T_EL_CYC` cycles.
- All outputs are registered. `lcd_e` is glitch-free.

## Configuration
- `LCD_NIBBLE_MODE_EN` defined: 4-bit bus. Only `lcd_db_in[7:4]` is used.
  - Each read is two E pulses: SETUP, E_HIGH/E_LOW for the high nibble, then E_HIGH/E_LOW for the low nibble. There is no second SETUP.
  - Latency is `T_AS_CYC+2*(T_EH_CYC+T_EL_CYC)+1`.
  - BF is evaluated from the high nibble. Poll count increments per byte.
- Not defined: 8-bit bus, single E pulse per read.

## Structure
- Package `lcd_pkg`:
  - state enum
  - `LCD_DB_W`=8
  - default timing constants
  - status-byte field positions (BF bit 7, AC bits 6:0)
- One sub-module, `lcd_phase_timer`: loadable down-counter sized to the largest `T_*_CYC`, with a `zero` flag that drives state transitions.
- Poll counter width: `$clog2(MAX_POLLS+1)`.

## Test plan
All cases use `T_AS_CYC`=1, `T_EH_CYC`=2, `T_EL_CYC`=2.
- Status read, `lcd_db_in`=0x25 → `lcd_e` high in cycles 2–3, `done` in cycle 6, `busy_flag`=0, `addr_cnt`=0x25, `lcd_rs`=0, `lcd_rw`=1 during the transaction.
- Data read, `rs_sel`=1, `lcd_db_in`=0x41 → `rdata`=0x41, `lcd_rs`=1, `busy_flag`/`addr_cnt` unchanged from the previous test.
- Poll, BF=1 for 3 reads then `lcd_db_in`=0x10 → exactly 4 E pulses, `done` in cycle 21, `timeout`=0, `addr_cnt`=0x10.
- `MAX_POLLS`=4, `lcd_db_in` stuck at 0x80 → 4 E pulses, then `done` with `timeout`=1, `busy_flag`=1. A `req` during the transaction is ignored.
- Reset asserted during E_HIGH → `lcd_e`/`bus_own`/`lcd_rw` go to 0 within the same cycle, no `done`. After release, `ready`=1 and a status read completes normally.
- `LCD_NIBBLE_MODE_EN`: `lcd_db_in[7:4]`=0xA on pulse 1 and 0x5 on pulse 2 → `rdata`=0xA5, `done` in cycle 10, `busy_flag`=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD read path.
//   state_e          read-cycle FSM states
//   LCD_DB_W         LCD data bus width
//   LCD_T_*_DEF      default phase lengths in clock cycles
//   LCD_BF_BIT/AC_*  status byte layout (busy flag, address counter)
//   lcd_max3()       largest of three cycle counts, sizes the phase timer
package lcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_ELOW,
        S_DONE
    } state_e;

    localparam int LCD_DB_W       = 8;
    localparam int LCD_T_AS_DEF   = 2;
    localparam int LCD_T_EH_DEF   = 25;
    localparam int LCD_T_EL_DEF   = 25;
    localparam int LCD_POLLS_DEF  = 255;
    localparam int LCD_BF_BIT     = 7;
    localparam int LCD_AC_MSB     = 6;
    localparam int LCD_AC_W       = LCD_AC_MSB + 1;

    function automatic int lcd_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable down-counter that times each bus phase.
//   clk, rst     clock, asynchronous active-low reset
//   load         load load_val this cycle (takes priority over counting)
//   load_val     cycles remaining minus one for the new phase
//   zero         counter has expired; the current phase ends on this edge
module lcd_phase_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    assign zero = (cnt_q == '0);

    always_comb cnt_d = load ? load_val : (zero ? cnt_q : cnt_q - 1'b1);

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

endmodule

// File: rtl/lcd_bf_reader.sv
// lcd_bf_reader: HD44780 read-cycle controller (status/busy-flag and data reads).
//   clk, rst                 clock, asynchronous active-low reset
//   req, rs_sel, poll        start a read (status or data), optionally poll BF
//   ready, done              idle indicator, one-cycle completion pulse
//   rdata, busy_flag,        last byte read, and BF/AC of the last status read
//   addr_cnt, timeout        timeout: polling gave up after MAX_POLLS reads
//   lcd_rs, lcd_rw, lcd_e    LCD control pins, all registered
//   lcd_db_in                LCD data bus input
//   bus_own                  this block currently owns the LCD control pins
// Build option: define LCD_NIBBLE_MODE_EN for a 4-bit bus (two E pulses per
// byte, high nibble first, data taken from lcd_db_in[7:4]).
module lcd_bf_reader
    import lcd_pkg::*;
#(
    parameter int T_AS_CYC  = LCD_T_AS_DEF,
    parameter int T_EH_CYC  = LCD_T_EH_DEF,
    parameter int T_EL_CYC  = LCD_T_EL_DEF,
    parameter int MAX_POLLS = LCD_POLLS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                rs_sel,
    input  logic                poll,
    output logic                ready,
    output logic                done,
    output logic [LCD_DB_W-1:0] rdata,
    output logic                busy_flag,
    output logic [LCD_AC_W-1:0] addr_cnt,
    output logic                timeout,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic                lcd_e,
    input  logic [LCD_DB_W-1:0] lcd_db_in,
    output logic                bus_own
);

    localparam int TW = $clog2(lcd_max3(T_AS_CYC, T_EH_CYC, T_EL_CYC) + 1);
    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam logic [TW-1:0] LD_AS = TW'(T_AS_CYC - 1);
    localparam logic [TW-1:0] LD_EH = TW'(T_EH_CYC - 1);
    localparam logic [TW-1:0] LD_EL = TW'(T_EL_CYC - 1);

    state_e                state_q, state_d;
    logic                  rs_q, rs_d, poll_q, poll_d;
    logic [PW-1:0]         cnt_q, cnt_d;
    logic [LCD_DB_W-1:0]   rdata_q, rdata_d, rd_byte;
    logic                  bf_q, bf_d, timeout_q, timeout_d;
    logic [LCD_AC_W-1:0]   ac_q, ac_d;
    logic                  ready_q, ready_d, done_q, done_d;
    logic                  lcd_rs_q, lcd_rs_d, lcd_rw_q, lcd_rw_d;
    logic                  lcd_e_q, lcd_e_d, own_q, own_d;
    logic                  ld, zero;
    logic [TW-1:0]         ld_val;
`ifdef LCD_NIBBLE_MODE_EN
    logic                  half_q, half_d;
    logic [3:0]            nib_q, nib_d;
`endif

    lcd_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .load_val (ld_val),
        .zero     (zero)
    );

`ifdef LCD_NIBBLE_MODE_EN
    assign rd_byte = {nib_q, lcd_db_in[7:4]};
`else
    assign rd_byte = lcd_db_in;
`endif

    always_comb begin
        state_d   = state_q;
        rs_d      = rs_q;
        poll_d    = poll_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        bf_d      = bf_q;
        ac_d      = ac_q;
        timeout_d = timeout_q;
        ld        = 1'b0;
        ld_val    = LD_AS;
`ifdef LCD_NIBBLE_MODE_EN
        half_d    = half_q;
        nib_d     = nib_q;
`endif
        unique case (state_q)
            S_IDLE: if (req) begin
                state_d   = S_SETUP;
                rs_d      = rs_sel;
                poll_d    = poll & ~rs_sel;
                cnt_d     = '0;
                timeout_d = 1'b0;
                ld        = 1'b1;
                ld_val    = LD_AS;
            end
            S_SETUP: if (zero) begin
                state_d = S_EHIGH;
                ld      = 1'b1;
                ld_val  = LD_EH;
`ifdef LCD_NIBBLE_MODE_EN
                half_d  = 1'b0;
`endif
            end
            S_EHIGH: if (zero) begin
                state_d = S_ELOW;
                ld      = 1'b1;
                ld_val  = LD_EL;
`ifdef LCD_NIBBLE_MODE_EN
                if (!half_q) nib_d = lcd_db_in[7:4];
                else
`endif
                begin
                    // Byte complete: one poll count per byte read
                    rdata_d = rd_byte;
                    cnt_d   = cnt_q + PW'(1);
                    if (!rs_q) begin
                        bf_d = rd_byte[LCD_BF_BIT];
                        ac_d = rd_byte[LCD_AC_MSB:0];
                    end
                end
            end
            S_ELOW: if (zero) begin
`ifdef LCD_NIBBLE_MODE_EN
                // Low nibble follows straight after, RS/RW already settled
                if (!half_q) begin
                    state_d = S_EHIGH;
                    half_d  = 1'b1;
                    ld      = 1'b1;
                    ld_val  = LD_EH;
                end else
`endif
                if (poll_q && bf_q && cnt_q < PW'(MAX_POLLS)) begin
                    state_d = S_SETUP;
                    ld      = 1'b1;
                    ld_val  = LD_AS;
                end else begin
                    state_d   = S_DONE;
                    timeout_d = poll_q & bf_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Pin/handshake outputs are decoded from the next state and registered
        ready_d  = (state_d == S_IDLE);
        done_d   = (state_d == S_DONE);
        lcd_e_d  = (state_d == S_EHIGH);
        own_d    = (state_d == S_SETUP) || (state_d == S_EHIGH) || (state_d == S_ELOW);
        lcd_rw_d = own_d;
        lcd_rs_d = own_d & rs_d;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q   <= S_IDLE;
            rs_q      <= 1'b0;
            poll_q    <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bf_q      <= 1'b0;
            ac_q      <= '0;
            timeout_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            lcd_rs_q  <= 1'b0;
            lcd_rw_q  <= 1'b0;
            lcd_e_q   <= 1'b0;
            own_q     <= 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
            half_q    <= 1'b0;
            nib_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rs_q      <= rs_d;
            poll_q    <= poll_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bf_q      <= bf_d;
            ac_q      <= ac_d;
            timeout_q <= timeout_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            lcd_rs_q  <= lcd_rs_d;
            lcd_rw_q  <= lcd_rw_d;
            lcd_e_q   <= lcd_e_d;
            own_q     <= own_d;
`ifdef LCD_NIBBLE_MODE_EN
            half_q    <= half_d;
            nib_q     <= nib_d;
`endif
        end

    assign ready     = ready_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign busy_flag = bf_q;
    assign addr_cnt  = ac_q;
    assign timeout   = timeout_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = lcd_rw_q;
    assign lcd_e     = lcd_e_q;
    assign bus_own   = own_q;

endmodule

// File: tb/tb_lcd_bf_reader.sv
// tb_lcd_bf_reader: table-driven, scoreboarded bench for lcd_bf_reader.
module tb_lcd_bf_reader;

    typedef struct {
        logic       rs_sel;
        logic       poll;
        int         nbusy;
        logic [7:0] busy_db;
        logic [7:0] final_db;
        logic       spur;
        logic [7:0] exp_rdata;
        logic       exp_bf;
        logic [6:0] exp_ac;
        logic       exp_to;
        int         exp_pulses;
        int         exp_lat;
    } vec_t;

    logic       clk = 0, rst = 0, req = 0, rs_sel = 0, poll = 0;
    logic [7:0] lcd_db_in = 0;
    logic       ready, done, busy_flag, timeout, lcd_rs, lcd_rw, lcd_e, bus_own;
    logic [7:0] rdata;
    logic [6:0] addr_cnt;

    int   n_checks = 0, n_fail = 0;
    vec_t vt[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    lcd_bf_reader #(.T_AS_CYC(1), .T_EH_CYC(2), .T_EL_CYC(2), .MAX_POLLS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rs_sel    (rs_sel),
        .poll      (poll),
        .ready     (ready),
        .done      (done),
        .rdata     (rdata),
        .busy_flag (busy_flag),
        .addr_cnt  (addr_cnt),
        .timeout   (timeout),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_db_in (lcd_db_in),
        .bus_own   (bus_own)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v);
        vec_t e;
        int   pulses, first_e, lat, extra;
        logic prev_e, bad, got;
        @(negedge clk);
        chk("ready_before_req", ready, 1);
        req       = 1;
        rs_sel    = v.rs_sel;
        poll      = v.poll;
        lcd_db_in = (v.nbusy > 0) ? v.busy_db : v.final_db;
        exp_q.push_back(v);
        pulses = 0; first_e = 0; lat = 0; prev_e = 0; bad = 0; got = 0;
        for (int cyc = 1; cyc <= 200 && !got; cyc++) begin
            @(negedge clk);
            req = (v.spur && cyc == 3);
            if (lcd_e && !prev_e) begin
                pulses++;
                if (first_e == 0) first_e = cyc;
            end
            if (!lcd_e && prev_e) lcd_db_in = (pulses < v.nbusy) ? v.busy_db : v.final_db;
            prev_e = lcd_e;
            if (bus_own && (!lcd_rw || lcd_rs !== v.rs_sel)) bad = 1;
            if (lcd_e && !bus_own) bad = 1;
            if (done) begin
                got = 1;
                lat = cyc;
                if (bus_own || lcd_rw || lcd_e || ready) bad = 1;
            end
        end
        req = 0;
        chk("done_seen", got, 1);
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rdata",     rdata,     e.exp_rdata);
            chk("busy_flag", busy_flag, e.exp_bf);
            chk("addr_cnt",  addr_cnt,  e.exp_ac);
            chk("timeout",   timeout,   e.exp_to);
            chk("e_pulses",  pulses,    e.exp_pulses);
            chk("latency",   lat,       e.exp_lat);
            chk("first_e",   first_e,   2);
            chk("bus_proto", bad,       0);
        end else exp_q.delete();
        if (v.spur) begin
            extra = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done || lcd_e || !ready) extra++;
            end
            chk("spur_req_ignored", extra, 0);
        end
    endtask

    initial begin
        vec_t pr;
        int   seen_e, dn;
`ifdef LCD_NIBBLE_MODE_EN
        vt.push_back('{0, 0, 1, 8'hA0, 8'h50, 0, 8'hA5, 1, 7'h25, 0, 2, 10});
        vt.push_back('{1, 0, 1, 8'h40, 8'h10, 0, 8'h41, 1, 7'h25, 0, 2, 10});
        vt.push_back('{0, 1, 1, 8'h80, 8'h10, 0, 8'h11, 0, 7'h11, 0, 4, 19});
        pr = '{0, 0, 1, 8'h30, 8'h70, 0, 8'h37, 0, 7'h37, 0, 2, 10};
`else
        vt.push_back('{0, 0, 0,   8'h00, 8'h25, 0, 8'h25, 0, 7'h25, 0, 1, 6});
        vt.push_back('{1, 0, 0,   8'h00, 8'h41, 0, 8'h41, 0, 7'h25, 0, 1, 6});
        vt.push_back('{0, 1, 3,   8'h85, 8'h10, 0, 8'h10, 0, 7'h10, 0, 4, 21});
        vt.push_back('{0, 1, 100, 8'h80, 8'h80, 1, 8'h80, 1, 7'h00, 1, 4, 21});
        vt.push_back('{0, 1, 0,   8'h00, 8'h05, 0, 8'h05, 0, 7'h05, 0, 1, 6});
        vt.push_back('{1, 1, 0,   8'h00, 8'h80, 0, 8'h80, 0, 7'h05, 0, 1, 6});
        pr = '{0, 0, 0, 8'h00, 8'h37, 0, 8'h37, 0, 7'h37, 0, 1, 6};
`endif
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bf", busy_flag, 0);
        chk("rst_ac", addr_cnt, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_pins", {lcd_e, bus_own, lcd_rw, lcd_rs}, 0);
        rst = 1;

        foreach (vt[i]) do_txn(vt[i]);

        // Reset in the middle of E_HIGH
        @(negedge clk);
        req = 1; rs_sel = 0; poll = 0; lcd_db_in = 8'hFF;
        seen_e = 0;
        for (int i = 0; i < 20 && !seen_e; i++) begin
            @(negedge clk);
            req = 0;
            if (lcd_e) seen_e = 1;
        end
        chk("reached_e_high", seen_e, 1);
        #1 rst = 0;
        #1;
        chk("async_drop_pins", {lcd_e, bus_own, lcd_rw}, 0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("no_done_after_rst", dn, 0);
        chk("ready_in_rst", ready, 1);
        chk("rdata_in_rst", rdata, 0);
        rst = 1;
        do_txn(pr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
